// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_if
// Description : Raw button inputs and conditioned command pulses for the
//               key_debounce button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_if;
    logic btn_next_raw;
    logic btn_pre_raw;
    logic btn_auto_raw;
    logic key_next;
    logic key_pre;
    logic key_auto;

    // Board / environment side: drives the buttons, consumes the pulses
    modport master (
        output btn_next_raw,
        output btn_pre_raw,
        output btn_auto_raw,
        input  key_next,
        input  key_pre,
        input  key_auto
    );

    // Conditioner side
    modport slave (
        input  btn_next_raw,
        input  btn_pre_raw,
        input  btn_auto_raw,
        output key_next,
        output key_pre,
        output key_auto
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises and debounces the next/previous/auto buttons and
//               turns accepted presses into single-cycle command pulses.
//               Next and previous auto-repeat while held; simultaneous
//               next/previous pulses cancel each other.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DEB_W      = 20,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 20_000_000,
    parameter int REP_W      = 26
) (
    input  wire           sysclk,
    input  wire           rst_n,
    key_debounce_if.slave bus
);

    localparam logic [DEB_W-1:0] c_deb_last        = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] c_rep_delay_last  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] c_rep_period_last = REP_W'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    // Channel order: 0 = next, 1 = previous, 2 = auto
    logic [2:0] w_raw;
    logic [2:0] w_stable;
    logic [2:0] w_rise;
    logic [1:0] w_rep_pulse;

    logic key_next_q, key_next_d;
    logic key_pre_q,  key_pre_d;
    logic key_auto_q, key_auto_d;

    assign w_raw = {bus.btn_auto_raw, bus.btn_pre_raw, bus.btn_next_raw};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic             s1_q, s1_d;
            logic             s2_q, s2_d;
            logic [DEB_W-1:0] cnt_q, cnt_d;
            logic             stable_q, stable_d;
            logic             stable_dly_q, stable_dly_d;

            // Synchronise, then accept s2 only after it has disagreed with
            // the accepted level for DEB_CYCLES consecutive edges
            always_comb begin
                s1_d         = w_raw[gi];
                s2_d         = s1_q;
                stable_dly_d = stable_q;
                stable_d     = stable_q;
                cnt_d        = cnt_q;
                if (s2_q == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_deb_last) begin
                    stable_d = s2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end

            // Synchroniser, debounce counter and accepted-level registers
            always_ff @(posedge sysclk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q         <= 1'b0;
                    s2_q         <= 1'b0;
                    cnt_q        <= '0;
                    stable_q     <= 1'b0;
                    stable_dly_q <= 1'b0;
                end else begin
                    s1_q         <= s1_d;
                    s2_q         <= s2_d;
                    cnt_q        <= cnt_d;
                    stable_q     <= stable_d;
                    stable_dly_q <= stable_dly_d;
                end
            end

            assign w_stable[gi] = stable_q;
            assign w_rise[gi]   = stable_q & ~stable_dly_q;
        end

        for (genvar gr = 0; gr < 2; gr++) begin : g_rep
            rep_state_t       state_q, state_d;
            logic [REP_W-1:0] rt_q, rt_d;
            logic             w_pulse;

            // Repeat FSM: pulse on press, again after REP_DELAY, then every
            // REP_PERIOD while the button stays accepted as held
            always_comb begin
                state_d = state_q;
                rt_d    = rt_q;
                w_pulse = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        rt_d = '0;
                        if (w_rise[gr]) begin
                            w_pulse = 1'b1;
                            state_d = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (!w_stable[gr]) begin
                            rt_d    = '0;
                            state_d = ST_IDLE;
                        end else if (rt_q == c_rep_delay_last) begin
                            w_pulse = 1'b1;
                            rt_d    = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            rt_d = rt_q + REP_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!w_stable[gr]) begin
                            rt_d    = '0;
                            state_d = ST_IDLE;
                        end else if (rt_q == c_rep_period_last) begin
                            w_pulse = 1'b1;
                            rt_d    = '0;
                        end else begin
                            rt_d = rt_q + REP_W'(1);
                        end
                    end
                    default: begin
                        rt_d    = '0;
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // Repeat FSM state and timer registers
            always_ff @(posedge sysclk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    rt_q    <= '0;
                end else begin
                    state_q <= state_d;
                    rt_q    <= rt_d;
                end
            end

            assign w_rep_pulse[gr] = w_pulse;
        end
    endgenerate

    // Next/previous cancel each other when both fire together; auto is
    // independent of that lockout
    always_comb begin
        key_next_d = w_rep_pulse[0] & ~w_rep_pulse[1];
        key_pre_d  = w_rep_pulse[1] & ~w_rep_pulse[0];
        key_auto_d = w_rise[2];
    end

    // Registered command outputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            key_next_q <= 1'b0;
            key_pre_q  <= 1'b0;
            key_auto_q <= 1'b0;
        end else begin
            key_next_q <= key_next_d;
            key_pre_q  <= key_pre_d;
            key_auto_q <= key_auto_d;
        end
    end

    assign bus.key_next = key_next_q;
    assign bus.key_pre  = key_pre_q;
    assign bus.key_auto = key_auto_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Scoreboard bench for key_debounce. A reference model derived
//               from the button-level rules predicts every command pulse; a
//               monitor compares the DUT outputs against that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int MAX_EDGES = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_debounce_if u_if ();

    key_debounce #(
        .DEB_CYCLES (DEB),
        .DEB_W      (4),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP),
        .REP_W      (5)
    ) dut (
        .sysclk (clk),
        .rst_n  (rst_n),
        .bus    (u_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit n;
        bit p;
        bit a;
    } ev_t;

    ev_t exp_q[$];
    int  gcyc   = 0;
    int  n_edge = 0;
    bit  smp [3][0:MAX_EDGES-1];
    bit  m_stab [3] = '{0, 0, 0};
    int  m_rise [3] = '{-1, -1, -1};
    int  seen   [3] = '{0, 0, 0};
    int  errors = 0;
    int  checks = 0;

    // Raw sample taken at edge k since reset; before edge 1 the
    // synchroniser holds 0
    function automatic bit sample_at(int c, int k);
        if (k < 1 || k >= MAX_EDGES) return 1'b0;
        return smp[c][k];
    endfunction

    // Reference model. Accepted level flips at edge n when the raw samples
    // taken at edges n-DEB-1 .. n-2 all disagree with it. A press accepted at
    // edge R yields pulses at edges R+1, R+1+RD, R+1+RD+k*RP for as long as
    // the level is still accepted before that edge.
    always @(posedge clk) begin
        bit   raw [3];
        bit   pl  [3];
        bit   all_diff;
        int   k;
        ev_t  e;
        gcyc++;
        if (!rst_n) begin
            n_edge = 0;
            for (int c = 0; c < 3; c++) begin
                m_stab[c] = 1'b0;
                m_rise[c] = -1;
            end
        end else begin
            n_edge++;
            raw[0] = u_if.btn_next_raw;
            raw[1] = u_if.btn_pre_raw;
            raw[2] = u_if.btn_auto_raw;
            for (int c = 0; c < 3; c++) begin
                if (n_edge < MAX_EDGES) smp[c][n_edge] = raw[c];
                pl[c] = 1'b0;
                if (m_stab[c] && m_rise[c] >= 0) begin
                    k = n_edge - m_rise[c] - 1;
                    if (c == 2) pl[c] = (k == 0);
                    else        pl[c] = (k == 0) || (k == RD) || (k > RD && ((k - RD) % RP) == 0);
                end
            end
            for (int c = 0; c < 3; c++) begin
                all_diff = 1'b1;
                for (int j = n_edge - DEB - 1; j <= n_edge - 2; j++)
                    if (sample_at(c, j) == m_stab[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stab[c] = ~m_stab[c];
                    m_rise[c] = m_stab[c] ? n_edge : -1;
                end
            end
            if (pl[0] && pl[1]) begin
                pl[0] = 1'b0;
                pl[1] = 1'b0;
            end
            if (pl[0] || pl[1] || pl[2]) begin
                e.cyc = gcyc;
                e.n   = pl[0];
                e.p   = pl[1];
                e.a   = pl[2];
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: outputs are sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        bit  gn, gp, ga;
        ev_t e;
        gn = u_if.key_next;
        gp = u_if.key_pre;
        ga = u_if.key_auto;
        if (gn) seen[0]++;
        if (gp) seen[1]++;
        if (ga) seen[2]++;
        while (exp_q.size() > 0 && exp_q[0].cyc < gcyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: got none, expected next/pre/auto=%0d%0d%0d at cycle %0d",
                     e.n, e.p, e.a, e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == gcyc) begin
            e = exp_q.pop_front();
            checks++;
            if ({gn, gp, ga} != {e.n, e.p, e.a}) begin
                errors++;
                $display("FAIL pulse_match: got next/pre/auto=%0d%0d%0d, expected %0d%0d%0d at cycle %0d",
                         gn, gp, ga, e.n, e.p, e.a, gcyc);
            end
        end else if (gn || gp || ga) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got next/pre/auto=%0d%0d%0d, expected 000 at cycle %0d",
                     gn, gp, ga, gcyc);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic drive(bit n, bit p, bit a, int len);
        for (int i = 0; i < len; i++) begin
            cyc();
            u_if.btn_next_raw = n;
            u_if.btn_pre_raw  = p;
            u_if.btn_auto_raw = a;
        end
    endtask

    task automatic check_outputs_zero(string name);
        checks++;
        if (u_if.key_next !== 1'b0 || u_if.key_pre !== 1'b0 || u_if.key_auto !== 1'b0) begin
            errors++;
            $display("FAIL %s: got next/pre/auto=%b%b%b, expected 000",
                     name, u_if.key_next, u_if.key_pre, u_if.key_auto);
        end
    endtask

    task automatic check_count(string name, int en, int ep, int ea);
        checks++;
        if (seen[0] != en || seen[1] != ep || seen[2] != ea) begin
            errors++;
            $display("FAIL %s: got pulse counts next/pre/auto=%0d/%0d/%0d, expected %0d/%0d/%0d",
                     name, seen[0], seen[1], seen[2], en, ep, ea);
        end
        seen = '{0, 0, 0};
    endtask

    initial begin
        bit lv [3];
        bit v  [3];
        bit bounce_seq [5];

        u_if.btn_next_raw = 1'b0;
        u_if.btn_pre_raw  = 1'b0;
        u_if.btn_auto_raw = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        drive(0, 0, 0, 6);
        seen = '{0, 0, 0};

        // Clean press: single pulse after edge 7
        drive(1, 0, 0, 8);
        drive(0, 0, 0, 20);
        check_count("clean_press", 1, 0, 0);

        // Bouncy press on previous, then held for 8 samples
        bounce_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) drive(0, bounce_seq[i], 0, 1);
        drive(0, 1, 0, 8);
        drive(0, 0, 0, 20);
        check_count("bounce_press", 0, 1, 0);

        // Hold for 30 samples: pulses at edges 7,17,20,...,35
        drive(1, 0, 0, 30);
        drive(0, 0, 0, 20);
        check_count("hold_repeat", 8, 0, 0);

        // Auto held: exactly one pulse
        drive(0, 0, 1, 40);
        drive(0, 0, 0, 20);
        check_count("auto_single", 0, 0, 1);

        // Lockout with concurrent auto press
        drive(1, 1, 1, 12);
        drive(0, 0, 0, 20);
        check_count("lockout", 0, 0, 1);

        // Reset during a repeat pulse, released with the button held
        drive(1, 0, 0, 20);
        cyc();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_hold");
        repeat (3) cyc();
        check_outputs_zero("reset_held");
        cyc();
        rst_n = 1'b1;
        drive(1, 0, 0, 17);
        drive(0, 0, 0, 20);
        check_count("reset_mid_hold_pulses", 7, 0, 0);

        // Randomised presses with occasional single-cycle glitches
        lv = '{0, 0, 0};
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 23) == 0) lv[c] = ~lv[c];
                v[c] = lv[c];
                if ($urandom_range(0, 9) == 0) v[c] = ~lv[c];
            end
            drive(v[0], v[1], v[2], 1);
        end
        drive(0, 0, 0, 30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected: got %0d undelivered pulses, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
# key_debounce

Button conditioner placed directly upstream of the slide-select stage. It synchronises and debounces the three raw board buttons (next, previous, auto) and emits single-cycle command pulses, so that one physical press advances the selected plot by exactly one. Next and previous additionally auto-repeat while held. The auto button produces one pulse per press, which the downstream stage uses as a toggle.

## Interface
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be ≥ 2.
- DEB_W, 20: debounce counter width; 2^DEB_W > DEB_CYCLES.
- REP_DELAY, 50_000_000: cycles from the press pulse to the first repeat pulse.
- REP_PERIOD, 20_000_000: cycles between subsequent repeat pulses.
- REP_W, 26: repeat timer width; 2^REP_W > max(REP_DELAY, REP_PERIOD).
- sysclk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_next_raw  in  1  raw "next" button, asynchronous, active-high, bouncy.
- btn_pre_raw  in  1  raw "previous" button, same properties.
- btn_auto_raw  in  1  raw "auto" button, same properties.
- key_next  out  1  one-cycle pulse: advance one plot.
- key_pre  out  1  one-cycle pulse: go back one plot.
- key_auto  out  1  one-cycle pulse: toggle auto play.

## Operation
- Per channel: 2-FF synchroniser (s1, s2), debounce counter `cnt`, and accepted level `stable`. All reset to 0.
- Debounce, evaluated each edge:
  - If s2 == stable, cnt <= 0.
  - Else if cnt == DEB_CYCLES-1, stable <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any bounce back to the stable level restarts the count.
  - Press and release are filtered identically.
- Press detect: rise = stable & ~stable_q, where stable_q is stable delayed one cycle. Release generates no pulse.
- Next and pre channels each have a repeat FSM with states IDLE, DELAY and REPEAT, plus a timer `rt` (REP_W bits):
  - IDLE: on rise, emit a pulse, set rt <= 0, go to DELAY.
  - DELAY: if stable == 0, go to IDLE. Else if rt == REP_DELAY-1, emit a pulse, set rt <= 0, go to REPEAT. Else rt <= rt+1.
  - REPEAT: if stable == 0, go to IDLE. Else if rt == REP_PERIOD-1, emit a pulse, set rt <= 0. Else rt <= rt+1.
- The auto channel has no repeat; it emits one pulse per rise only.
- Conflict lockout:
  - If next and pre would pulse in the same cycle, both are suppressed.
  - Both FSMs still advance normally.
  - key_auto is independent of the lockout.
- Outputs are registered. key_next, key_pre and key_auto are never high for two consecutive cycles from a single event.

## Timing
- Reset: all outputs 0, all FSMs in IDLE, all counters 0. The reset takes effect asynchronously and is released on the next sysclk edge.
- Press latency: the raw input is first sampled high at edge 1 and then held clean. Output:
  - s2 = 1 after edge 2.
  - stable = 1 after edge DEB_CYCLES+2.
  - key_* is high for exactly the one cycle following edge DEB_CYCLES+3.
- Repeat timing: if the initial pulse is in cycle P, repeats occur at P+REP_DELAY, then every REP_PERIOD cycles, while stable remains 1.
- Release latency: stable falls DEB_CYCLES+2 edges after the raw input falls. Repeats stop from that edge; no pulse is in flight afterwards.
- Glitch rule: a raw pulse or bounce shorter than DEB_CYCLES cycles (after synchronisation) never changes stable.
- Reset mid-press clears everything. A button still held when reset deasserts is treated as a fresh press: one pulse after DEB_CYCLES+3 edges.
- Timers never wrap: they are cleared at every terminal count and when stable is 0.

## Test plan
Test parameters: DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3.
- Clean press: btn_next_raw held high from edge 1 for 8 cycles, then low → key_next high only in the cycle after edge 7. key_pre = key_auto = 0 throughout.
- Bounce: btn_pre_raw toggles 1,0,1,1,0 on successive edges, then holds 1 → no pulse during the toggling. Exactly one key_pre pulse, 7 edges after the final rising sample.
- Hold repeat: btn_next_raw held for 30 cycles → key_next pulses at P, P+10, P+13, P+16, …. Pulses stop within DEB_CYCLES+2 edges of release.
- Auto: btn_auto_raw held for 40 cycles → exactly one key_auto pulse, at the cycle after edge 7.
- Lockout: btn_next_raw and btn_pre_raw rise on the same edge and are both held for 12 cycles → no key_next or key_pre pulse at all. btn_auto_raw pressed concurrently → key_auto pulse still appears.
- Reset mid-hold: assert rst_n=0 during the REPEAT state → all outputs drop to 0 immediately. Release rst_n with the button still held → one key_next pulse 7 edges later, then a repeat 10 cycles after that.
